// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add step per clock, LSB first, fixed WIDTH+2 cycle turnaround.
// Optional signed-overflow flag is built only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  // Partial result holds the low WIDTH-1 bits; the final step supplies the MSB.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-2:0] res_shift;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic ha_s, ha_c, step_s, step_c, last_step;

  // Full-add step as two half-adder stages.
  assign ha_s      = opa_q[0] ^ opb_q[0];
  assign ha_c      = opa_q[0] & opb_q[0];
  assign step_s    = ha_s ^ carry_q;
  assign step_c    = ha_c | (ha_s & carry_q);
  assign last_step = (state_q == RUN) && (cnt_q == LAST);

  generate
    if (WIDTH == 2) begin : g_res_narrow
      assign res_shift = step_s;
    end else begin : g_res_wide
      assign res_shift = {step_s, res_q[WIDTH-2:1]};
    end
  endgenerate

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = res_shift;
        carry_d = step_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          sum_d   = {step_s, res_q};
          cout_d  = step_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of order.
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // On the last step carry_q is the carry into the MSB and step_c the carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last_step) ovf_d = carry_q ^ step_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table plus hand-written
// sequences for held start, input toggling and mid-run reset, scored through a queue.
module tb_serial_adder;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;   // value expected when the overflow flag is built
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = OVF_EN & o;
    sb_q.push_back(e);
  endtask

  // Scoreboard: results are compared mid-cycle whenever done is high.
  always @(negedge clk) begin
    if (done) begin
      check("busy_with_done", {31'd0, busy}, 32'd0);
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum",  {24'd0, sum},  {24'd0, e.sum});
        check("cout", {31'd0, cout}, {31'd0, e.cout});
        check("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
      end
    end
  end

  // Called #1 after the accepting edge; follows the run to the end of DONE.
  task automatic wait_done(input string tag);
    int lat = 0;
    int busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      cin = 1'($urandom);
    end
    check({tag, "_latency"}, lat, WIDTH);
    check({tag, "_busy_cycles"}, busy_cnt, WIDTH);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, {30'd0, done, busy}, 32'd0);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    push_exp(v.sum, v.cout, v.ovf);
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    wait_done(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    //           a      b      cin   sum    cout  ovf
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {24'd0, sum},  32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // start held high with operands toggling: one result, re-accept at edge WIDTH+2
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    push_exp(8'h33, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 1; i <= WIDTH + 1; i++) begin
      @(negedge clk);
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
    end
    check("hold_idle_before_reaccept", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    a = 8'h40; b = 8'h02; cin = 1'b1;
    push_exp(8'h43, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("hold_reaccept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("hold2");

    // Reset at RUN step 4: outputs clear immediately, no done pulse
    @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum",  {24'd0, sum},  32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_ovf",  {31'd0, ovf},  32'd0);
    repeat (3) @(negedge clk);

    // First edge after release accepts the next start
    rst_n = 1'b1;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    push_exp(8'h30, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("accept_after_reset", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("post_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
